// File: rtl/ucode_seq_if.sv
// ucode_seq_if: sequencer control, handshake, microcode-write and status signals.
interface ucode_seq_if #(
    parameter int OP_W  = 5,
    parameter int STEPS = 8,
    parameter int CW    = 32
);
    localparam int SW = $clog2(STEPS);
    logic [OP_W-1:0]    opcode;
    logic               mem_ready;
    logic               cond;
    logic               trap;
    logic               halt;
    logic               prog_we;
    logic [OP_W+SW-1:0] prog_addr;
    logic [CW+2:0]      prog_data;
    logic [CW-1:0]      ctrl;
    logic [SW-1:0]      step;
    logic               retire;
    logic               seq_err;
    logic               trap_ack;
    logic [63:0]        instret;
    modport master (
        output opcode, mem_ready, cond, trap, halt, prog_we, prog_addr, prog_data,
        input  ctrl, step, retire, seq_err, trap_ack, instret
    );
    modport slave (
        input  opcode, mem_ready, cond, trap, halt, prog_we, prog_addr, prog_data,
        output ctrl, step, retire, seq_err, trap_ack, instret
    );
endinterface

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: writable microcode store stepping one microword per cycle.
// Define UCODE_SEQ_INSTRET_EN to build the 64-bit retired-microprogram counter.
module ucode_sequencer #(
    parameter int OP_W  = 5,
    parameter int STEPS = 8,
    parameter int CW    = 32
) (
    input logic        clk,
    input logic        reset,
    ucode_seq_if.slave bus
);
    localparam int SW = $clog2(STEPS);
    typedef enum logic [2:0] {
        S_NEXT = 3'd0,
        S_END  = 3'd1,
        S_WAIT = 3'd2,
        S_COND = 3'd3,
        S_WEND = 3'd4
    } seq_e;
    logic [CW+2:0] mem_q [2**(OP_W+SW)];
    logic [SW-1:0] step_q, step_d;
    logic [CW+2:0] word;
    seq_e          seq;
    logic          last, adv, retire, seq_err, trap_ack;
    assign word = mem_q[{bus.opcode, step_q}];
    assign seq  = seq_e'(word[CW+2:CW]);
    assign last = &step_q;
    // The store is deliberately outside the reset domain so microcode survives reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_data;
    end
    always_ff @(posedge clk) begin
        step_q <= step_d;
    end
    always_comb begin
        step_d   = step_q;
        retire   = 1'b0;
        seq_err  = 1'b0;
        trap_ack = 1'b0;
        adv      = 1'b0;
        if (reset) begin
            step_d = '0;
        end else if (bus.trap) begin
            step_d   = '0;
            trap_ack = 1'b1;
        end else if (!bus.halt) begin
            case (seq)
                S_NEXT: adv = 1'b1;
                S_END: begin
                    step_d = '0;
                    retire = 1'b1;
                end
                S_WAIT: adv = bus.mem_ready;
                S_COND: begin
                    adv    = bus.cond;
                    retire = !bus.cond;
                    step_d = bus.cond ? step_q : '0;
                end
                S_WEND: begin
                    retire = bus.mem_ready;
                    step_d = bus.mem_ready ? '0 : step_q;
                end
                default: begin
                    step_d  = '0;
                    seq_err = 1'b1;
                end
            endcase
            // Advancing past the last step is an overflow error, never a silent wrap.
            if (adv) begin
                step_d  = last ? '0 : step_q + SW'(1);
                seq_err = last;
            end
        end
    end
    assign bus.ctrl     = (reset || bus.trap || bus.halt) ? '0 : word[CW-1:0];
    assign bus.step     = step_q;
    assign bus.retire   = retire;
    assign bus.seq_err  = seq_err;
    assign bus.trap_ack = trap_ack;
`ifdef UCODE_SEQ_INSTRET_EN
    logic [63:0] instret_q;
    always_ff @(posedge clk) begin
        if (reset) instret_q <= '0;
        else if (retire) instret_q <= instret_q + 64'd1;
    end
    assign bus.instret = instret_q;
`else
    assign bus.instret = '0;
`endif
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed microprograms with hand-computed expectations.
module tb_ucode_sequencer;
    localparam int OP_W = 5, STEPS = 8, CW = 32;
`ifdef UCODE_SEQ_INSTRET_EN
    localparam bit IE = 1'b1;
`else
    localparam bit IE = 1'b0;
`endif
    logic clk, reset;
    int total = 0, bad = 0, nret = 0;
    logic [63:0] exp_ir = 0;
    ucode_seq_if #(.OP_W(OP_W), .STEPS(STEPS), .CW(CW)) u_if ();
    ucode_sequencer #(.OP_W(OP_W), .STEPS(STEPS), .CW(CW)) dut (
        .clk(clk), .reset(reset), .bus(u_if.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) if (u_if.retire === 1'b1) nret++;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic prog(input int op, input int st, input logic [2:0] sq, input logic [31:0] c);
        u_if.prog_we   = 1'b1;
        u_if.prog_addr = 8'(op * STEPS + st);
        u_if.prog_data = {sq, c};
        @(negedge clk);
        u_if.prog_we = 1'b0;
    endtask
    task automatic chk_ir(input string tag);
        chk(tag, u_if.instret, IE ? exp_ir : 64'd0);
    endtask
    initial begin
        reset = 1'b1;
        u_if.opcode = '0; u_if.mem_ready = 0; u_if.cond = 0; u_if.trap = 0;
        u_if.halt = 0; u_if.prog_we = 0; u_if.prog_addr = '0; u_if.prog_data = '0;
        @(negedge clk);
        for (int a = 0; a < 2**OP_W * STEPS; a++) prog(a / STEPS, a % STEPS, 3'd1, 32'h0);
        prog(3, 0, 3'd0, 32'h1); prog(3, 1, 3'd0, 32'h2); prog(3, 2, 3'd1, 32'h4);
        prog(0, 0, 3'd0, 32'h20); prog(0, 1, 3'd2, 32'h40); prog(0, 2, 3'd1, 32'h80);
        for (int i = 0; i < 3; i++) prog(5, i, 3'd0, 32'h0);
        prog(5, 3, 3'd3, 32'h8); prog(5, 4, 3'd1, 32'h10);
        for (int i = 0; i < 8; i++) prog(7, i, 3'd0, 32'(i + 1));
        prog(9, 0, 3'd0, 32'h0); prog(9, 1, 3'd0, 32'h0); prog(9, 2, 3'd2, 32'h100); prog(9, 3, 3'd1, 32'h0);
        prog(11, 0, 3'd0, 32'h0); prog(11, 1, 3'd0, 32'h0); prog(11, 2, 3'd7, 32'h3);
        prog(12, 0, 3'd4, 32'h7);
        u_if.opcode = 5'd3;
        #1;
        chk("rst_step", u_if.step, 0);
        chk("rst_ctrl", u_if.ctrl, 0);
        chk("rst_retire", u_if.retire, 0);
        chk("rst_seqerr", u_if.seq_err, 0);
        chk("rst_trapack", u_if.trap_ack, 0);
        chk("rst_instret", u_if.instret, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            u_if.halt = 0;
            #1;
            chk("op3_c0", u_if.ctrl, 32'h1);
            tick(); chk("op3_c1", u_if.ctrl, 32'h2); chk("op3_s1", u_if.step, 1);
            chk("op3_noret", u_if.retire, 0);
            tick(); chk("op3_c2", u_if.ctrl, 32'h4); chk("op3_ret", u_if.retire, 1);
            tick(); exp_ir++; chk("op3_s0", u_if.step, 0); chk_ir("op3_ir");
            u_if.halt = 1;
            #1;
            chk("halt_ctrl", u_if.ctrl, 0);
        end
        chk("ret_pulses", 64'(nret), 3);
        u_if.halt = 0; tick(); chk("hold_s1", u_if.step, 1);
        u_if.halt = 1; #1; chk("hold_ret", u_if.retire, 0); chk("hold_ctrl", u_if.ctrl, 0);
        tick(); chk("hold_s1b", u_if.step, 1);
        u_if.halt = 0; #1; chk("hold_ctrl2", u_if.ctrl, 32'h2);
        tick(); chk("hold_ret2", u_if.retire, 1);
        tick(); exp_ir++; chk_ir("hold_ir"); u_if.halt = 1;
        u_if.opcode = 5'd0; u_if.halt = 0; #1;
        chk("wait_c0", u_if.ctrl, 32'h20);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("wait_hold_s", u_if.step, 1); chk("wait_hold_c", u_if.ctrl, 32'h40);
        end
        u_if.mem_ready = 1; #1; chk("wait_5th", u_if.ctrl, 32'h40);
        tick(); u_if.mem_ready = 0; chk("wait_adv", u_if.step, 2); chk("wait_c2", u_if.ctrl, 32'h80);
        tick(); exp_ir++; chk("wait_s0", u_if.step, 0); u_if.halt = 1;
        u_if.opcode = 5'd5; u_if.halt = 0;
        for (int i = 1; i < 4; i++) begin tick(); chk("cond_s", u_if.step, i); end
        chk("cond0_ret", u_if.retire, 1);
        tick(); exp_ir++; chk("cond0_s0", u_if.step, 0); u_if.cond = 1;
        for (int i = 1; i < 4; i++) tick();
        chk("cond1_noret", u_if.retire, 0); chk("cond1_noerr", u_if.seq_err, 0);
        tick(); chk("cond1_s4", u_if.step, 4); chk("cond1_c", u_if.ctrl, 32'h10);
        tick(); exp_ir++; chk("cond1_s0", u_if.step, 0); u_if.halt = 1; u_if.cond = 0;
        u_if.opcode = 5'd7; u_if.halt = 0; #1;
        for (int i = 0; i < 7; i++) begin
            chk("ovf_c", u_if.ctrl, 64'(i + 1)); tick();
        end
        chk("ovf_s7", u_if.step, 7); chk("ovf_err", u_if.seq_err, 1); chk("ovf_noret", u_if.retire, 0);
        tick(); chk("ovf_s0", u_if.step, 0); chk_ir("ovf_ir"); u_if.halt = 1;
        u_if.opcode = 5'd9; u_if.halt = 0; tick(); tick();
        chk("trap_s2", u_if.step, 2); chk("trap_c2", u_if.ctrl, 32'h100);
        u_if.trap = 1; u_if.halt = 1; #1;
        chk("trap_ack", u_if.trap_ack, 1); chk("trap_ctrl", u_if.ctrl, 0); chk("trap_noret", u_if.retire, 0);
        tick(); u_if.trap = 0; chk("trap_s0", u_if.step, 0);
        u_if.opcode = 5'd11; u_if.halt = 0; tick(); tick();
        chk("ill_err", u_if.seq_err, 1); chk("ill_noret", u_if.retire, 0);
        tick(); chk("ill_s0", u_if.step, 0); chk_ir("ill_ir"); u_if.halt = 1;
        u_if.opcode = 5'd12; u_if.halt = 0; #1;
        chk("wend_c", u_if.ctrl, 32'h7); chk("wend_noret", u_if.retire, 0);
        tick(); chk("wend_hold", u_if.step, 0);
        u_if.prog_we = 1; u_if.prog_addr = 8'(12 * STEPS); u_if.prog_data = {3'd4, 32'h55}; #1;
        chk("wr_before", u_if.ctrl, 32'h7);
        @(negedge clk); u_if.prog_we = 0; #1;
        chk("wr_after", u_if.ctrl, 32'h55);
        u_if.mem_ready = 1; #1; chk("wend_ret", u_if.retire, 1);
        tick(); exp_ir++; chk_ir("wend_ir"); u_if.mem_ready = 0; u_if.halt = 1;
        u_if.opcode = 5'd3; u_if.halt = 0; tick();
        chk("mid_s1", u_if.step, 1);
        reset = 1; u_if.trap = 1; #1;
        chk("mid_ctrl", u_if.ctrl, 0); chk("mid_noret", u_if.retire, 0); chk("mid_noack", u_if.trap_ack, 0);
        tick(); reset = 0; u_if.trap = 0; #1;
        chk("mid_s0", u_if.step, 0); chk("mid_ir0", u_if.instret, 0); chk("mid_keep", u_if.ctrl, 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
